// File: rtl/square_move_collector.sv
// ---------------------------------------------------------------------------
// square_move_collector
//
// Snapshots the 16 move words produced by one square cell, discards empty
// words and words whose mover colour differs from the side to move, and
// streams the surviving words out one per valid/ready handshake, lowest slot
// index first.
//
// Ports:
//   clk          in   1    system clock, rising edge
//   clear        in   1    synchronous active-high reset, highest priority
//   enable       in   1    0 freezes all state and forces move_valid low
//   engineColor  in   1    side to move (1 = white, 0 = black)
//   load         in   1    snapshot request, honoured only in IDLE
//   move_in      in   512  slot i at bits [32i+31:32i]
//   move_out     out  32   current move word (lowest live slot)
//   move_valid   out  1    move_out carries a live move
//   move_ready   in   1    downstream takes move_out this cycle
//   busy         out  1    state is not IDLE
//   done         out  1    one-cycle pulse once a snapshot is drained
//   move_count   out  5    moves handed off from the current/last snapshot
// ---------------------------------------------------------------------------
module square_move_collector #(
   parameter int NUM_SLOTS = 16,
   parameter int CNT_W     = 5
) (
   input  logic                    clk,
   input  logic                    clear,
   input  logic                    enable,
   input  logic                    engineColor,
   input  logic                    load,
   input  logic [NUM_SLOTS*32-1:0] move_in,
   output logic [31:0]             move_out,
   output logic                    move_valid,
   input  logic                    move_ready,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        move_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [NUM_SLOTS-1:0] ONE_MASK = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

   state_t                  state_r;
   logic [NUM_SLOTS*32-1:0] slots_r;
   logic [NUM_SLOTS-1:0]    mask_r;
   logic [CNT_W-1:0]        count_r;

   logic [NUM_SLOTS-1:0]    live_s;
   logic [NUM_SLOTS-1:0]    lowest_s;
   logic [NUM_SLOTS-1:0]    mask_next_s;
   logic [31:0]             word_s;
   logic                    handshake_s;

   // Live-slot detection on the incoming words: non-zero and mover colour
   // (bit 13) matching the side to move.
   always_comb begin
      live_s = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if ((move_in[32*i +: 32] != 32'd0) && (move_in[32*i + 13] == engineColor)) begin
            live_s[i] = 1'b1;
         end else begin
            live_s[i] = 1'b0;
         end
      end
   end

   // Priority select: isolate the lowest set mask bit as a one-hot vector and
   // AND-OR the matching word out. An empty mask yields a zero word.
   always_comb begin
      lowest_s    = mask_r & (~mask_r + ONE_MASK);
      mask_next_s = mask_r & ~lowest_s;
      word_s      = 32'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (lowest_s[i]) begin
            word_s = word_s | slots_r[32*i +: 32];
         end else begin
            word_s = word_s;
         end
      end
   end

   assign handshake_s = enable && (state_r == SCAN) && move_ready;

   // Output decode from registered state; enable only gates the valid flag.
   always_comb begin
      move_out   = word_s;
      move_valid = enable && (state_r == SCAN);
      busy       = (state_r != IDLE);
      done       = (state_r == DONE);
      move_count = count_r;
   end

   // Control FSM, snapshot storage and hand-off counter.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_r <= IDLE;
         slots_r <= '0;
         mask_r  <= '0;
         count_r <= '0;
      end else if (enable) begin
         case (state_r)
            IDLE: begin
               if (load) begin
                  slots_r <= move_in;
                  mask_r  <= live_s;
                  count_r <= '0;
                  state_r <= (live_s != '0) ? SCAN : DONE;
               end else begin
                  state_r <= IDLE;
               end
            end
            SCAN: begin
               if (handshake_s) begin
                  mask_r  <= mask_next_s;
                  count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  state_r <= (mask_next_s == '0) ? DONE : SCAN;
               end else begin
                  state_r <= SCAN;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               mask_r  <= '0;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

endmodule

// File: tb/tb_square_move_collector.sv
// ---------------------------------------------------------------------------
// tb_square_move_collector
//
// Directed bench for square_move_collector. Each scenario task drives its own
// stimulus and compares DUT outputs against hand-computed values. Inputs are
// changed 1 time unit after a rising edge; outputs are checked 1 time unit
// after that, so comparisons never sit on the active edge.
// ---------------------------------------------------------------------------
module tb_square_move_collector;

   logic         clk = 1'b0;
   logic         clear;
   logic         enable;
   logic         engineColor;
   logic         load;
   logic [511:0] move_in;
   logic [31:0]  move_out;
   logic         move_valid;
   logic         move_ready;
   logic         busy;
   logic         done;
   logic [4:0]   move_count;

   int tests = 0;
   int fails = 0;

   localparam logic [31:0] M1  = 32'h001C_1814;
   localparam logic [31:0] M1W = 32'h001C_3814;
   localparam logic [31:0] M6  = 32'h001C_0813;
   localparam logic [31:0] M9  = 32'h001C_012B;

   square_move_collector #(.NUM_SLOTS(16), .CNT_W(5)) dut (
      .clk        (clk),
      .clear      (clear),
      .enable     (enable),
      .engineColor(engineColor),
      .load       (load),
      .move_in    (move_in),
      .move_out   (move_out),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .busy       (busy),
      .done       (done),
      .move_count (move_count)
   );

   always #5 clk = ~clk;

   // advance to 1 unit after the next rising edge
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] three_moves(input logic [31:0] s1);
      logic [511:0] v;
      v = '0;
      v[32*1 +: 32] = s1;
      v[32*6 +: 32] = M6;
      v[32*9 +: 32] = M9;
      return v;
   endfunction

   task automatic test_reset;
      clear = 1'b1; enable = 1'b1; engineColor = 1'b0; load = 1'b0;
      move_in = '0; move_ready = 1'b0;
      next_cycle();
      clear = 1'b0;
      #1;
      tests++; if (move_out !== 32'd0) begin fails++; $display("FAIL reset_out: got %h want %h", move_out, 32'd0); end
      tests++; if (move_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", move_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (move_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", move_count); end
   endtask

   task automatic test_three_moves;
      logic [31:0] exp_w [3];
      exp_w[0] = M1; exp_w[1] = M6; exp_w[2] = M9;
      engineColor = 1'b0; move_ready = 1'b1;
      move_in = three_moves(M1); load = 1'b1;
      next_cycle();
      load = 1'b0; move_in = '0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tests++; if (move_valid !== 1'b1) begin fails++; $display("FAIL three_valid[%0d]: got %b want 1", i, move_valid); end
         tests++; if (move_out !== exp_w[i]) begin fails++; $display("FAIL three_out[%0d]: got %h want %h", i, move_out, exp_w[i]); end
         next_cycle();
      end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL three_done: got %b want 1", done); end
      tests++; if (move_count !== 5'd3) begin fails++; $display("FAIL three_count: got %0d want 3", move_count); end
      tests++; if (move_valid !== 1'b0) begin fails++; $display("FAIL three_valid_after: got %b want 0", move_valid); end
      next_cycle();
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL three_idle: got busy=%b done=%b want 0 0", busy, done); end
      tests++; if (move_count !== 5'd3) begin fails++; $display("FAIL three_count_hold: got %0d want 3", move_count); end
   endtask

   task automatic test_colour_filter;
      engineColor = 1'b0; move_ready = 1'b1;
      move_in = three_moves(M1W); load = 1'b1;
      next_cycle();
      load = 1'b0; move_in = '0;
      #1;
      tests++; if (move_out !== M6) begin fails++; $display("FAIL colour_out0: got %h want %h", move_out, M6); end
      next_cycle();
      tests++; if (move_out !== M9) begin fails++; $display("FAIL colour_out1: got %h want %h", move_out, M9); end
      next_cycle();
      tests++; if (done !== 1'b1 || move_count !== 5'd2) begin fails++; $display("FAIL colour_done: got done=%b count=%0d want 1 2", done, move_count); end
      next_cycle();
   endtask

   task automatic test_backpressure;
      engineColor = 1'b0; move_ready = 1'b0;
      move_in = three_moves(M1); load = 1'b1;
      next_cycle();
      load = 1'b0; move_in = '0;
      #1;
      for (int i = 0; i < 5; i++) begin
         tests++; if (move_valid !== 1'b1 || move_out !== M1) begin fails++; $display("FAIL bp_hold[%0d]: got valid=%b out=%h want 1 %h", i, move_valid, move_out, M1); end
         tests++; if (move_count !== 5'd0) begin fails++; $display("FAIL bp_count[%0d]: got %0d want 0", i, move_count); end
         if (i < 4) next_cycle();
      end
      move_ready = 1'b1;
      next_cycle();
      tests++; if (move_out !== M6 || move_count !== 5'd1) begin fails++; $display("FAIL bp_resume0: got out=%h count=%0d want %h 1", move_out, move_count, M6); end
      next_cycle();
      tests++; if (move_out !== M9 || move_count !== 5'd2) begin fails++; $display("FAIL bp_resume1: got out=%h count=%0d want %h 2", move_out, move_count, M9); end
      next_cycle();
      tests++; if (done !== 1'b1 || move_count !== 5'd3) begin fails++; $display("FAIL bp_done: got done=%b count=%0d want 1 3", done, move_count); end
      next_cycle();
   endtask

   task automatic test_empty_and_scan_load;
      logic [511:0] other;
      other = '0;
      other[31:0] = 32'h001C_0102;
      engineColor = 1'b0; move_ready = 1'b1;
      move_in = '0; load = 1'b1;
      next_cycle();
      load = 1'b0;
      #1;
      tests++; if (done !== 1'b1 || move_valid !== 1'b0 || move_count !== 5'd0) begin fails++; $display("FAIL empty_done: got done=%b valid=%b count=%0d want 1 0 0", done, move_valid, move_count); end
      next_cycle();
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL empty_idle: got busy=%b done=%b want 0 0", busy, done); end
      // load during SCAN must leave the snapshot alone
      move_ready = 1'b0; move_in = three_moves(M1); load = 1'b1;
      next_cycle();
      move_in = other;
      #1;
      tests++; if (move_out !== M1) begin fails++; $display("FAIL scanload_c1: got %h want %h", move_out, M1); end
      next_cycle();
      tests++; if (move_out !== M1 || move_count !== 5'd0) begin fails++; $display("FAIL scanload_c2: got out=%h count=%0d want %h 0", move_out, move_count, M1); end
      move_ready = 1'b1;
      next_cycle();
      load = 1'b0;
      #1;
      tests++; if (move_out !== M6) begin fails++; $display("FAIL scanload_c3: got %h want %h", move_out, M6); end
      next_cycle();
      tests++; if (move_out !== M9) begin fails++; $display("FAIL scanload_c4: got %h want %h", move_out, M9); end
      next_cycle();
      tests++; if (done !== 1'b1 || move_count !== 5'd3) begin fails++; $display("FAIL scanload_done: got done=%b count=%0d want 1 3", done, move_count); end
      move_in = '0;
      next_cycle();
   endtask

   task automatic test_clear_mid_scan;
      engineColor = 1'b0; move_ready = 1'b1;
      move_in = three_moves(M1); load = 1'b1;
      next_cycle();
      load = 1'b0;
      #1;
      tests++; if (move_out !== M1) begin fails++; $display("FAIL clr_c1: got %h want %h", move_out, M1); end
      next_cycle();
      tests++; if (move_out !== M6 || move_count !== 5'd1) begin fails++; $display("FAIL clr_c2: got out=%h count=%0d want %h 1", move_out, move_count, M6); end
      clear = 1'b1;
      next_cycle();
      clear = 1'b0;
      #1;
      tests++; if (move_out !== 32'd0 || move_valid !== 1'b0) begin fails++; $display("FAIL clr_outs: got out=%h valid=%b want 0 0", move_out, move_valid); end
      tests++; if (busy !== 1'b0 || done !== 1'b0 || move_count !== 5'd0) begin fails++; $display("FAIL clr_state: got busy=%b done=%b count=%0d want 0 0 0", busy, done, move_count); end
      load = 1'b1;
      next_cycle();
      load = 1'b0; move_in = '0;
      #1;
      tests++; if (move_out !== M1 || move_count !== 5'd0) begin fails++; $display("FAIL clr_replay0: got out=%h count=%0d want %h 0", move_out, move_count, M1); end
      next_cycle();
      tests++; if (move_out !== M6) begin fails++; $display("FAIL clr_replay1: got %h want %h", move_out, M6); end
      next_cycle();
      tests++; if (move_out !== M9) begin fails++; $display("FAIL clr_replay2: got %h want %h", move_out, M9); end
      next_cycle();
      tests++; if (done !== 1'b1 || move_count !== 5'd3) begin fails++; $display("FAIL clr_replay_done: got done=%b count=%0d want 1 3", done, move_count); end
      next_cycle();
   endtask

   task automatic test_enable;
      engineColor = 1'b0; move_ready = 1'b1;
      move_in = three_moves(M1); load = 1'b1;
      next_cycle();
      load = 1'b0; move_in = '0;
      next_cycle();
      tests++; if (move_out !== M6 || move_count !== 5'd1) begin fails++; $display("FAIL en_pre: got out=%h count=%0d want %h 1", move_out, move_count, M6); end
      enable = 1'b0;
      #1;
      tests++; if (move_valid !== 1'b0 || move_out !== M6 || busy !== 1'b1) begin fails++; $display("FAIL en_off: got valid=%b out=%h busy=%b want 0 %h 1", move_valid, move_out, busy, M6); end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         tests++; if (move_valid !== 1'b0 || move_count !== 5'd1 || move_out !== M6) begin fails++; $display("FAIL en_frozen[%0d]: got valid=%b count=%0d out=%h want 0 1 %h", i, move_valid, move_count, move_out, M6); end
      end
      enable = 1'b1;
      #1;
      tests++; if (move_valid !== 1'b1 || move_out !== M6) begin fails++; $display("FAIL en_back: got valid=%b out=%h want 1 %h", move_valid, move_out, M6); end
      next_cycle();
      tests++; if (move_out !== M9 || move_count !== 5'd2) begin fails++; $display("FAIL en_next: got out=%h count=%0d want %h 2", move_out, move_count, M9); end
      next_cycle();
      tests++; if (done !== 1'b1 || move_count !== 5'd3) begin fails++; $display("FAIL en_done: got done=%b count=%0d want 1 3", done, move_count); end
      next_cycle();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL en_idle: got busy=%b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_three_moves();
      test_colour_filter();
      test_backpressure();
      test_empty_and_scan_load();
      test_clear_mid_scan();
      test_enable();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
